// File: rtl/fsm_flip_run_monitor.sv
// fsm_flip_run_monitor
// Consumes a serial bit stream together with the flip pulse of a Mealy bit-flip
// detector. It measures the length of each run between flips, reports every
// completed run (bit value and length), pulses a violation flag once per run that
// grows longer than MAX_RUN, and keeps a saturating count of flips.
// Optional build macro: FLIP_MON_XCHK_EN adds a sticky det/ser_in consistency
// checker on xchk_err; without it xchk_err is tied low.
module fsm_flip_run_monitor #(
    parameter int CNT_W      = 8,
    parameter int MAX_RUN    = 5,
    parameter int FLIP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ser_in,
    input  logic                  det,
    output logic [CNT_W-1:0]      run_len,
    output logic                  run_bit,
    output logic                  run_vld,
    output logic                  viol,
    output logic [FLIP_CNT_W-1:0] flip_cnt,
    output logic                  xchk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        VIOL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]      LEN_MAX  = '1;
    localparam logic [CNT_W-1:0]      RUN_LIM  = CNT_W'(MAX_RUN);
    localparam logic [FLIP_CNT_W-1:0] FLIP_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc_len(input logic [CNT_W-1:0] v);
        return (v == LEN_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [FLIP_CNT_W-1:0] sat_inc_flip(input logic [FLIP_CNT_W-1:0] v);
        return (v == FLIP_MAX) ? v : v + FLIP_CNT_W'(1);
    endfunction

    state_t                  r_state;
    logic                    r_cur_bit;
    logic [CNT_W-1:0]        r_cur_len;
    logic [CNT_W-1:0]        r_run_len;
    logic                    r_run_bit;
    logic                    r_run_vld;
    logic                    r_viol;
    logic [FLIP_CNT_W-1:0]   r_flip_cnt;

    state_t                  w_state;
    logic                    w_cur_bit;
    logic [CNT_W-1:0]        w_cur_len;
    logic [CNT_W-1:0]        w_run_len;
    logic                    w_run_bit;
    logic                    w_run_vld;
    logic                    w_viol;
    logic [FLIP_CNT_W-1:0]   w_flip_cnt;

    // Next-state and next-output logic; run tracking always follows det.
    always_comb begin
        w_state    = r_state;
        w_cur_bit  = r_cur_bit;
        w_cur_len  = r_cur_len;
        w_run_len  = r_run_len;
        w_run_bit  = r_run_bit;
        w_run_vld  = 1'b0;
        w_viol     = 1'b0;
        w_flip_cnt = r_flip_cnt;
        if (en) begin
            case (r_state)
                IDLE: begin
                    // No previous bit exists yet, so det carries no meaning here.
                    w_cur_bit = ser_in;
                    w_cur_len = CNT_W'(1);
                    w_state   = RUN;
                end
                RUN, VIOL: begin
                    if (det) begin
                        w_run_len  = r_cur_len;
                        w_run_bit  = r_cur_bit;
                        w_run_vld  = 1'b1;
                        w_cur_bit  = ser_in;
                        w_cur_len  = CNT_W'(1);
                        w_flip_cnt = sat_inc_flip(r_flip_cnt);
                        w_state    = RUN;
                    end else begin
                        w_cur_len = sat_inc_len(r_cur_len);
                        // Only RUN can flag, so an overlong run yields exactly one pulse.
                        if (r_state == RUN && r_cur_len == RUN_LIM) begin
                            w_viol  = 1'b1;
                            w_state = VIOL;
                        end
                    end
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cur_bit  <= 1'b0;
            r_cur_len  <= '0;
            r_run_len  <= '0;
            r_run_bit  <= 1'b0;
            r_run_vld  <= 1'b0;
            r_viol     <= 1'b0;
            r_flip_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_cur_bit  <= w_cur_bit;
            r_cur_len  <= w_cur_len;
            r_run_len  <= w_run_len;
            r_run_bit  <= w_run_bit;
            r_run_vld  <= w_run_vld;
            r_viol     <= w_viol;
            r_flip_cnt <= w_flip_cnt;
        end
    end

`ifdef FLIP_MON_XCHK_EN
    logic r_xchk_err;
    logic w_xchk_err;
    logic w_local_flip;

    // Sticky flag when det disagrees with a flip seen locally against the open run.
    always_comb begin
        w_local_flip = (ser_in != r_cur_bit);
        w_xchk_err   = r_xchk_err;
        if (en && (r_state == RUN || r_state == VIOL) && (det != w_local_flip)) begin
            w_xchk_err = 1'b1;
        end
    end

    // Checker flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xchk_err <= 1'b0;
        end else begin
            r_xchk_err <= w_xchk_err;
        end
    end

    assign xchk_err = r_xchk_err;
`else
    assign xchk_err = 1'b0;
`endif

    assign run_len  = r_run_len;
    assign run_bit  = r_run_bit;
    assign run_vld  = r_run_vld;
    assign viol     = r_viol;
    assign flip_cnt = r_flip_cnt;

endmodule
